// File: rtl/memory_arbiter.sv
// Two-master arbiter sharing one registered memory request/response port.
// Define MEM_ARB_RR_EN for round-robin ties; otherwise M0 has fixed priority.
module memory_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                reqValid_M0,
  input  logic [ADDR_W-1:0]   reqAddress_M0,
  input  logic [DATA_W-1:0]   reqDataOut_M0,
  input  logic                reqWen_M0,
  input  logic [DATA_W/8-1:0] reqStrobe_M0,
  input  logic                reqValid_M1,
  input  logic [ADDR_W-1:0]   reqAddress_M1,
  input  logic [DATA_W-1:0]   reqDataOut_M1,
  input  logic                reqWen_M1,
  input  logic [DATA_W/8-1:0] reqStrobe_M1,
  output logic                respValid_M0,
  output logic [DATA_W-1:0]   respDataIn_M0,
  output logic                respValid_M1,
  output logic [DATA_W-1:0]   respDataIn_M1,
  output logic                reqValid_MEM,
  output logic [ADDR_W-1:0]   reqAddress_MEM,
  output logic [DATA_W-1:0]   reqDataOut_MEM,
  output logic                reqWen_MEM,
  output logic [DATA_W/8-1:0] reqStrobe_MEM,
  input  logic                respValid_MEM,
  input  logic [DATA_W-1:0]   respDataIn_MEM,
  output logic [1:0]          grant
);

  typedef enum logic {IDLE, BUSY} state_e;

  state_e              state_q, state_d;
  logic [1:0]          grant_q, grant_d;
  logic                vld_q, vld_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                wen_q, wen_d;
  logic [DATA_W/8-1:0] strb_q, strb_d;
  logic                pick1;

`ifdef MEM_ARB_RR_EN
  // last_q set means M1 owned the previous grant, so M0 wins the next tie
  logic last_q, last_d;

  assign pick1 = reqValid_M1 & (~reqValid_M0 | ~last_q);

  always_ff @(posedge clk) begin
    if (!rst) last_q <= 1'b1;
    else      last_q <= last_d;
  end
`else
  assign pick1 = reqValid_M1 & ~reqValid_M0;
`endif

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    vld_d   = vld_q;
    addr_d  = addr_q;
    data_d  = data_q;
    wen_d   = wen_q;
    strb_d  = strb_q;
`ifdef MEM_ARB_RR_EN
    last_d  = last_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (reqValid_M0 | reqValid_M1) begin
          state_d = BUSY;
          vld_d   = 1'b1;
          grant_d = pick1 ? 2'b10 : 2'b01;
          addr_d  = pick1 ? reqAddress_M1 : reqAddress_M0;
          data_d  = pick1 ? reqDataOut_M1 : reqDataOut_M0;
          wen_d   = pick1 ? reqWen_M1 : reqWen_M0;
          strb_d  = pick1 ? reqStrobe_M1 : reqStrobe_M0;
`ifdef MEM_ARB_RR_EN
          last_d  = pick1;
`endif
        end
      end
      BUSY: begin
        if (respValid_MEM) begin
          state_d = IDLE;
          vld_d   = 1'b0;
          grant_d = 2'b00;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      grant_q <= 2'b00;
      vld_q   <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      wen_q   <= 1'b0;
      strb_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      vld_q   <= vld_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      wen_q   <= wen_d;
      strb_q  <= strb_d;
    end
  end

  // grant is only non-zero while BUSY, so an IDLE response is dropped
  assign respValid_M0   = rst & grant_q[0] & respValid_MEM;
  assign respValid_M1   = rst & grant_q[1] & respValid_MEM;
  assign respDataIn_M0  = respDataIn_MEM;
  assign respDataIn_M1  = respDataIn_MEM;
  assign reqValid_MEM   = vld_q;
  assign reqAddress_MEM = addr_q;
  assign reqDataOut_MEM = data_q;
  assign reqWen_MEM     = wen_q;
  assign reqStrobe_MEM  = strb_q;
  assign grant          = grant_q;

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter: vector table plus corner sequences.
// Expectations follow the build: MEM_ARB_RR_EN selects round-robin results.
module tb_memory_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        v0, v1, w0, w1, rv;
  logic [31:0] a0, a1, d0, d1, rd;
  logic [3:0]  s0, s1;
  logic        r0, r1, vm, wm;
  logic [31:0] rd0, rd1, am, dm;
  logic [3:0]  sm;
  logic [1:0]  g;

  int total = 0;
  int passed = 0;

`ifdef MEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  always #5 clk = ~clk;

  memory_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .reqValid_M0(v0), .reqAddress_M0(a0), .reqDataOut_M0(d0),
    .reqWen_M0(w0), .reqStrobe_M0(s0),
    .reqValid_M1(v1), .reqAddress_M1(a1), .reqDataOut_M1(d1),
    .reqWen_M1(w1), .reqStrobe_M1(s1),
    .respValid_M0(r0), .respDataIn_M0(rd0),
    .respValid_M1(r1), .respDataIn_M1(rd1),
    .reqValid_MEM(vm), .reqAddress_MEM(am), .reqDataOut_MEM(dm),
    .reqWen_MEM(wm), .reqStrobe_MEM(sm),
    .respValid_MEM(rv), .respDataIn_MEM(rd),
    .grant(g)
  );

  typedef struct {
    logic       rst, v0, v1, rv;
    logic [1:0] g;
    logic       vm, r0, r1;
    logic [31:0] addr;
  } vec_t;

  vec_t tbl[16];

  function automatic vec_t mk(logic rs, logic q0, logic q1, logic qr,
                              logic [1:0] eg, logic evm, logic e0,
                              logic e1, logic [31:0] ea);
    vec_t t;
    t.rst = rs; t.v0 = q0; t.v1 = q1; t.rv = qr;
    t.g = eg; t.vm = evm; t.r0 = e0; t.r1 = e1; t.addr = ea;
    return t;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  logic [1:0]  g2;
  logic [31:0] a2;

  initial begin
    g2 = RR ? 2'b10 : 2'b01;
    a2 = RR ? 32'h200 : 32'h100;
    tbl[0]  = mk(0,1,1,0, 2'b00,0,0,0, 32'h0);
    tbl[1]  = mk(0,1,1,0, 2'b00,0,0,0, 32'h0);
    tbl[2]  = mk(1,1,1,0, 2'b00,0,0,0, 32'h0);
    tbl[3]  = mk(1,1,1,0, 2'b01,1,0,0, 32'h100);
    tbl[4]  = mk(1,1,1,1, 2'b01,1,1,0, 32'h100);
    tbl[5]  = mk(1,1,1,0, 2'b00,0,0,0, 32'h100);
    tbl[6]  = mk(1,1,1,0, g2,   1,0,0, a2);
    tbl[7]  = mk(1,1,1,1, g2,   1,!RR,RR, a2);
    tbl[8]  = mk(1,1,1,0, 2'b00,0,0,0, a2);
    tbl[9]  = mk(1,1,1,0, 2'b01,1,0,0, 32'h100);
    tbl[10] = mk(1,1,1,1, 2'b01,1,1,0, 32'h100);
    tbl[11] = mk(1,1,1,0, 2'b00,0,0,0, 32'h100);
    tbl[12] = mk(1,1,1,0, g2,   1,0,0, a2);
    tbl[13] = mk(1,1,1,1, g2,   1,!RR,RR, a2);
    tbl[14] = mk(1,0,0,1, 2'b00,0,0,0, a2);
    tbl[15] = mk(1,0,0,0, 2'b00,0,0,0, a2);

    rst = 1'b0; v0 = 1'b1; v1 = 1'b1; rv = 1'b0; rd = '0;
    a0 = 32'h100; d0 = 32'hA0; w0 = 1'b0; s0 = 4'h1;
    a1 = 32'h200; d1 = 32'hB0; w1 = 1'b0; s1 = 4'h2;
    cyc();

    for (int i = 0; i < 16; i++) begin
      rst = tbl[i].rst; v0 = tbl[i].v0; v1 = tbl[i].v1; rv = tbl[i].rv;
      #1;
      chk($sformatf("v%0d grant", i), {30'd0, g}, {30'd0, tbl[i].g});
      chk($sformatf("v%0d vmem", i), {31'd0, vm}, {31'd0, tbl[i].vm});
      chk($sformatf("v%0d resp0", i), {31'd0, r0}, {31'd0, tbl[i].r0});
      chk($sformatf("v%0d resp1", i), {31'd0, r1}, {31'd0, tbl[i].r1});
      chk($sformatf("v%0d addr", i), am, tbl[i].addr);
      if (i == 2) begin
        chk("rst data", dm, 32'h0);
        chk("rst wen", {31'd0, wm}, 32'h0);
        chk("rst strb", {28'd0, sm}, 32'h0);
      end
      cyc();
    end

    // M1 alone writes; fields held through BUSY
    rv = 1'b0; v0 = 1'b0; v1 = 1'b1;
    a1 = 32'h40; d1 = 32'hDEADBEEF; w1 = 1'b1; s1 = 4'hF;
    cyc();
    for (int k = 0; k < 3; k++) begin
      chk("wr grant", {30'd0, g}, 32'h2);
      chk("wr vmem", {31'd0, vm}, 32'h1);
      chk("wr addr", am, 32'h40);
      chk("wr data", dm, 32'hDEADBEEF);
      chk("wr wen", {31'd0, wm}, 32'h1);
      chk("wr strb", {28'd0, sm}, 32'hF);
      cyc();
    end
    rv = 1'b1;
    #1;
    chk("wr resp1", {31'd0, r1}, 32'h1);
    chk("wr resp0", {31'd0, r0}, 32'h0);
    cyc();
    rv = 1'b0; v1 = 1'b0; w1 = 1'b0; s1 = 4'h2;
    #1;
    chk("wr done resp1", {31'd0, r1}, 32'h0);
    chk("wr done grant", {30'd0, g}, 32'h0);
    chk("wr done vmem", {31'd0, vm}, 32'h0);
    cyc();

    // M0 read, 5-cycle latency, M1 arrives mid-BUSY
    v0 = 1'b1; a0 = 32'h80; w0 = 1'b0;
    cyc();
    for (int k = 0; k < 5; k++) begin
      if (k == 1) begin v1 = 1'b1; a1 = 32'h300; end
      #1;
      chk("rd grant", {30'd0, g}, 32'h1);
      chk("rd addr", am, 32'h80);
      chk("rd resp0", {31'd0, r0}, 32'h0);
      cyc();
    end
    rv = 1'b1; rd = 32'h12345678;
    #1;
    chk("rd resp0 R", {31'd0, r0}, 32'h1);
    chk("rd resp1 R", {31'd0, r1}, 32'h0);
    chk("rd data0", rd0, 32'h12345678);
    chk("rd data1", rd1, 32'h12345678);
    cyc();
    rv = 1'b0; v0 = 1'b0;
    #1;
    chk("R+1 grant", {30'd0, g}, 32'h0);
    chk("R+1 vmem", {31'd0, vm}, 32'h0);
    cyc();
    chk("R+2 grant", {30'd0, g}, 32'h2);
    chk("R+2 vmem", {31'd0, vm}, 32'h1);
    chk("R+2 addr", am, 32'h300);
    rv = 1'b1;
    #1;
    chk("M1 resp", {31'd0, r1}, 32'h1);
    cyc();
    rv = 1'b0; v1 = 1'b0;
    cyc();

    // reset mid-BUSY, stale response dropped, M1 then completes
    v0 = 1'b1; a0 = 32'h500;
    cyc();
    chk("mid grant", {30'd0, g}, 32'h1);
    rst = 1'b0; v0 = 1'b0;
    cyc();
    chk("mid rst grant", {30'd0, g}, 32'h0);
    chk("mid rst vmem", {31'd0, vm}, 32'h0);
    chk("mid rst addr", am, 32'h0);
    rst = 1'b1; rv = 1'b1;
    #1;
    chk("stale resp0", {31'd0, r0}, 32'h0);
    chk("stale resp1", {31'd0, r1}, 32'h0);
    cyc();
    rv = 1'b0; v1 = 1'b1; a1 = 32'h600;
    #1;
    chk("stale idle", {30'd0, g}, 32'h0);
    cyc();
    chk("new grant", {30'd0, g}, 32'h2);
    chk("new addr", am, 32'h600);
    rv = 1'b1;
    #1;
    chk("new resp1", {31'd0, r1}, 32'h1);
    cyc();
    rv = 1'b0; v1 = 1'b0;
    #1;
    chk("new done", {30'd0, g}, 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
